// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with registered result and flags.
//   Single-cycle ADD/SUB/XOR/SLT/NAND/NOR. SLL/SRA run iteratively, one bit per cycle.
//   Build option: define ALU_SEQ_SHIFT_EN to enable the iterative shifter. Without it,
//   ops 6/7 complete in one cycle with result 0 and err set.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready    upstream handshake; op, operand_a, operand_b sampled on accept
//   out_valid / out_ready  downstream handshake; result and flags held until taken
//   result                 registered result (WIDTH bits)
//   carryout               ADD carry, SUB no-borrow, else 0
//   overflow               ADD/SUB signed overflow, else 0
//   zero                   result == 0
//   err                    unsupported opcode
module alu_seq_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             err
);
   localparam logic [2:0] OpAdd  = 3'd0;
   localparam logic [2:0] OpSub  = 3'd1;
   localparam logic [2:0] OpXor  = 3'd2;
   localparam logic [2:0] OpSlt  = 3'd3;
   localparam logic [2:0] OpNand = 3'd4;
   localparam logic [2:0] OpNor  = 3'd5;

   logic             accept, idle, start_shift;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   // Shared adder: SUB and SLT compute A + ~B + 1.
   logic             sub_mode;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             add_ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_err;

   assign sub_mode = (op == OpSub) || (op == OpSlt);
   assign b_eff    = sub_mode ? ~operand_b : operand_b;
   assign sum      = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
   assign add_ovf  = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != operand_a[WIDTH-1]);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op)
         OpAdd, OpSub: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = add_ovf;
         end
         OpXor:  alu_res = operand_a ^ operand_b;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
         OpNand: alu_res = ~(operand_a & operand_b);
         OpNor:  alu_res = ~(operand_a | operand_b);
         default: begin
`ifdef ALU_SEQ_SHIFT_EN
            // Only reached for a zero shift amount; non-zero amounts go to the shifter.
            alu_res = operand_a;
`else
            alu_err = 1'b1;
`endif
         end
      endcase
   end

`ifdef ALU_SEQ_SHIFT_EN
   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d, sh_step;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             sra_q, sra_d;
   logic [SHW-1:0]   shamt;

   assign shamt       = operand_b[SHW-1:0];
   assign idle        = (state_q == StIdle);
   assign start_shift = accept && (op[2:1] == 2'b11) && (shamt != '0);
   assign sh_step     = sra_q ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
`else
   assign idle        = 1'b1;
   assign start_shift = 1'b0;
`endif

   assign in_ready = idle && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      err_d       = err_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept && !start_shift) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         carry_d     = alu_c;
         ovf_d       = alu_v;
         zero_d      = (alu_res == '0);
         err_d       = alu_err;
      end
`ifdef ALU_SEQ_SHIFT_EN
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      sra_d   = sra_q;
      case (state_q)
         StIdle: begin
            if (start_shift) begin
               state_d = StShift;
               sh_d    = operand_a;
               cnt_d   = shamt;
               sra_d   = op[0];
            end
         end
         StShift: begin
            sh_d  = sh_step;
            cnt_d = cnt_q - 1'b1;
            // Last step: publish the shifted value directly so no extra cycle is spent.
            if (cnt_q == SHW'(1)) begin
               state_d     = StIdle;
               out_valid_d = 1'b1;
               result_d    = sh_step;
               carry_d     = 1'b0;
               ovf_d       = 1'b0;
               zero_d      = (sh_step == '0);
               err_d       = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
      end
   end

`ifdef ALU_SEQ_SHIFT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         sh_q    <= '0;
         cnt_q   <= '0;
         sra_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         sra_q   <= sra_d;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carryout  = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=32). Stimulus pushes expected responses computed
// by a plain-arithmetic reference model; a negedge monitor pops and compares on each output
// handshake and also checks that held outputs stay stable. Works with or without
// ALU_SEQ_SHIFT_EN defined.
`timescale 1ns/1ps
module tb_alu_seq_core;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         carryout, overflow, zero, err;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;  // 0: out_ready low, 1: high, 2: random

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      logic         zf;
      logic         er;
   } exp_t;

   exp_t sb_q[$];
   bit   prev_hold = 1'b0;
   exp_t prev_out;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carryout  (carryout),
      .overflow  (overflow),
      .zero      (zero),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model straight from the opcode definitions.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t               e;
      longint             sa, sb, s;
      logic [W:0]         wide;
      logic signed [W-1:0] sra_in;
      e  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin
            wide   = {1'b0, a} + {1'b0, b};
            e.res  = wide[W-1:0];
            e.cout = wide[W];
            s      = sa + sb;
            e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            e.res  = a - b;
            e.cout = (a >= b);
            s      = sa - sb;
            e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: e.res = a ^ b;
         3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: e.res = ~(a & b);
         3'd5: e.res = ~(a | b);
         3'd6: begin
`ifdef ALU_SEQ_SHIFT_EN
            e.res = a << b[4:0];
`else
            e.er = 1'b1;
`endif
         end
         default: begin
`ifdef ALU_SEQ_SHIFT_EN
            sra_in = a;
            e.res  = sra_in >>> b[4:0];
`else
            e.er = 1'b1;
`endif
         end
      endcase
      e.zf = (e.res == '0);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compare on every output handshake; check held outputs are stable.
   always @(negedge clk) begin
      exp_t cur, e;
      cur = {result, carryout, overflow, zero, err};
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(cur), 64'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("scoreboard", 64'(cur), 64'(e));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_out  = cur;
      end
   end

   // Present an op and hold it until accepted; expectation is queued at the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n         = 0;
      op        = o;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(n), 64'd0);
      end else begin
         sb_q.push_back(model(o, a, b));
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      op        = 3'($urandom_range(0, 7));
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   // Called right after the accept edge: counts busy cycles before out_valid rises.
   task automatic wait_out(output int busy);
      busy = 0;
      while (!out_valid && busy < 100) begin
         chk("busy_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
         busy++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      ready_mode = 1;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int         busy, seen;
      logic [2:0] o;
      logic [W-1:0] a, b;

      // Reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_flags", 64'({result, carryout, overflow, zero, err}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // ADD overflow boundary, latency 1
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      chk("add_lat1_valid", 64'(out_valid), 64'd1);
      chk("add_ovf_result", 64'({result, carryout, overflow}), {30'd0, 32'h8000_0000, 2'b01});

      // SUB / SLT corners, back-to-back
      issue(3'd1, 32'd5, 32'd7);
      issue(3'd3, 32'h8000_0000, 32'h0000_0001);
      issue(3'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd1, 32'd7, 32'd7);
      issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
      drain();

      // Output held while out_ready is low
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      issue(3'd0, 32'd1, 32'd2);
      op        = 3'd0;
      operand_a = 32'd10;
      operand_b = 32'd20;
      in_valid  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_result", 64'(result), 64'd3);
      end
      ready_mode = 1;
      issue(3'd0, 32'd10, 32'd20);
      drain();

`ifdef ALU_SEQ_SHIFT_EN
      // SRA by 4: four shift cycles, in_ready low throughout
      issue(3'd7, 32'h8000_0000, 32'd4);
      wait_out(busy);
      chk("sra4_busy", 64'(busy), 64'd4);
      chk("sra4_result", 64'(result), 64'hF800_0000);
      // Shift amount uses only the low bits: 32 -> shift by 0, completes in one cycle
      issue(3'd6, 32'h0000_0005, 32'd32);
      wait_out(busy);
      chk("sll0_busy", 64'(busy), 64'd0);
      chk("sll0_result", 64'(result), 64'd5);
      drain();
      // Reset in the middle of a long shift
      ready_mode = 0;
      issue(3'd6, 32'h0000_0001, 32'd20);
`else
      // Shifts unsupported: one cycle, result 0, zero and err set
      issue(3'd6, 32'h0000_0001, 32'h0000_0003);
      wait_out(busy);
      chk("noshift_busy", 64'(busy), 64'd0);
      chk("noshift_out", 64'({result, zero, err}), {30'd0, 32'd0, 2'b11});
      drain();
      // Reset while a result is held
      ready_mode = 0;
      issue(3'd0, 32'h0000_0001, 32'h0000_0001);
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_release_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("no_stale_output", 64'(seen), 64'd0);
      ready_mode = 1;
      issue(3'd0, 32'd2, 32'd3);
      drain();

      // Randomised traffic with random back-pressure
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         o = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         if (o >= 3'd6 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 7));
         issue(o, a, b);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
